mod_mul: RTL and testbench
==========================

MOD_MUL -- requirements
Module: mod_mul

Interface
REQ-001 Parameters DATA_WIDTH and MODULUS SHALL come from parameters_pkg, not module parameters: DATA_WIDTH (448) = operand width; MODULUS = field prime p.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  DATA_WIDTH  multiplicand, required < MODULUS.
REQ-006 b  input  DATA_WIDTH  multiplier, required < MODULUS; fed directly by the upstream modular subtractor's result.
REQ-007 result  output  DATA_WIDTH  registered (a*b) mod MODULUS.
REQ-008 done  output  1  level; high while result is valid.
REQ-009 busy  output  1  high while a multiplication is in progress.

Function
REQ-010 Algorithm SHALL be MSB-first interleaved shift-add modular multiplication over bits of b.
REQ-011 States SHALL be IDLE, RUN and DONE.
REQ-012 IDLE with start=1 at edge k:
- latch a and b internally
- clear accumulator acc
- load bit counter = DATA_WIDTH-1
- enter RUN
- busy=1, done=0.
REQ-013 Each RUN edge SHALL process one bit b[cnt]:
- t = 2*acc; if t >= MODULUS then t -= MODULUS
- if b[cnt]: t += a; if t >= MODULUS then t -= MODULUS
- acc <= t.
REQ-014 Intermediates SHALL be DATA_WIDTH+2 bits wide; acc SHALL be < MODULUS after every step.
REQ-015 On the edge that processes bit 0:
- result <= final acc
- done <= 1, busy <= 0
- enter DONE.
- Latency = DATA_WIDTH edges after the start edge (448).
REQ-016 DONE SHALL hold result and done until start=1, which acts as in IDLE: done drops on that edge.
REQ-017 start in RUN SHALL be ignored; latched operands and acc stay unchanged.
REQ-018 Changes on a, b during RUN SHALL have no effect on the result.
REQ-019 result SHALL keep its last value in IDLE and RUN; it updates only on entry to DONE.
REQ-020 Behaviour for a or b >= MODULUS SHALL be unspecified; result SHALL still be < MODULUS.

Reset
REQ-021 rst=1 at any edge SHALL force:
- state=IDLE
- result=0, done=0, busy=0
- acc=0, counter=0.
REQ-022 rst SHALL take priority over start and over an in-progress RUN; the aborted operation produces no done.
REQ-023 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro MOD_MUL_RADIX4_EN SHALL select digit size.
REQ-025 When defined, each RUN edge processes two bits b[cnt], b[cnt-1], MSB first: two chained REQ-013 steps in one cycle.
- Counter steps by 2.
- Latency = DATA_WIDTH/2 edges (224).
REQ-026 When undefined, behaviour SHALL be exactly REQ-013/REQ-015: radix 2, latency DATA_WIDTH.
REQ-027 Results SHALL be bit-identical in both configurations; only latency differs.

Verification
REQ-028 a=3, b=5, start pulse -> done after 448 cycles (224 with macro), result=15.
REQ-029 a=MODULUS-1, b=MODULUS-1 -> result=1. a=MODULUS-1, b=2 -> result=MODULUS-2.
REQ-030 a=0, b=MODULUS-1 -> result=0, done=1. Then a=1, b=0x1234 -> result=0x1234.
REQ-031 Upstream-chain check: b = subtractor output 1-2 = MODULUS-1 and a=7 -> result=MODULUS-7.
REQ-032 Start a=3, b=5; pulse start with a=9, b=9 at cycle 100 -> ignored, result=15 at cycle 448.
REQ-033 rst=1 at cycle 200 of a run -> next edge result=0, done=0, busy=0. New start a=2, b=2 -> result=4.

Source files
------------

// File: rtl/parameters_pkg.sv
// Shared field parameters for the modular arithmetic datapath.
// MODULUS is the Goldilocks prime 2^448 - 2^224 - 1.
package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  localparam logic [DATA_WIDTH-1:0] MODULUS =
    {{(DATA_WIDTH/2-1){1'b1}}, 1'b0, {(DATA_WIDTH/2){1'b1}}};
endpackage

// File: rtl/mod_mul_if.sv
// Request/response bundle for mod_mul: operands and start in, result and status out.
interface mod_mul_if;
  import parameters_pkg::*;
  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] result;
  logic                  done;
  logic                  busy;

  modport master (output start, a, b, input  result, done, busy);
  modport slave  (input  start, a, b, output result, done, busy);
endinterface

// File: rtl/mod_mul.sv
// MSB-first interleaved shift-add modular multiplier, result = (a*b) mod MODULUS.
// Define MOD_MUL_RADIX4_EN to retire two multiplier bits per cycle (half latency).
module mod_mul
  import parameters_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mod_mul_if.slave   bus
);
  localparam int W  = DATA_WIDTH + 2;
  localparam int CW = $clog2(DATA_WIDTH);
  typedef logic [W-1:0] ext_t;
  localparam ext_t MOD_X = ext_t'(MODULUS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef MOD_MUL_RADIX4_EN
  localparam logic [CW-1:0] CNT_STEP = CW'(2);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
`else
  localparam logic [CW-1:0] CNT_STEP = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(0);
`endif

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  ext_t                  acc_nxt;

  // One radix-2 step: double, reduce, conditionally add a, reduce.
  // Requires acc < MODULUS and a < MODULUS, which keeps the result < MODULUS.
  function automatic ext_t step(input ext_t acc, input logic bit_i, input ext_t av);
    ext_t t;
    t = acc << 1;
    if (t >= MOD_X) t = t - MOD_X;
    if (bit_i) begin
      t = t + av;
      if (t >= MOD_X) t = t - MOD_X;
    end
    return t;
  endfunction

  always_comb begin
`ifdef MOD_MUL_RADIX4_EN
    acc_nxt = step(step(ext_t'(acc_q), b_q[cnt_q], ext_t'(a_q)),
                   b_q[cnt_q - CW'(1)], ext_t'(a_q));
`else
    acc_nxt = step(ext_t'(acc_q), b_q[cnt_q], ext_t'(a_q));
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Out-of-range a (< 2*MODULUS) is folded once so every step stays reduced.
          a_d     = (ext_t'(bus.a) >= MOD_X) ? (bus.a - MODULUS) : bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = CW'(DATA_WIDTH - 1);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nxt[DATA_WIDTH-1:0];
        if (cnt_q == CNT_LAST) begin
          result_d = acc_nxt[DATA_WIDTH-1:0];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_mod_mul.sv
// Directed self-checking bench for mod_mul over the Goldilocks prime field.
module tb_mod_mul;
  import parameters_pkg::*;
  localparam int W = DATA_WIDTH;
`ifdef MOD_MUL_RADIX4_EN
  localparam int LAT = DATA_WIDTH / 2;
`else
  localparam int LAT = DATA_WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mod_mul_if bus ();
  mod_mul u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, " busy@start"}, W'(bus.busy), W'(1));
    chk({tag, " done@start"}, W'(bus.done), W'(0));
  endtask

  // Waits (bounded) for done; rem is the exact number of edges expected.
  task automatic wait_done(input int rem, input logic [W-1:0] exp, input string tag);
    int n;
    n = 0;
    while (!bus.done && n < LAT + 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, W'(n), W'(rem));
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " busy@done"}, W'(bus.busy), W'(0));
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp, input string tag);
    issue(av, bv, tag);
    wait_done(LAT, exp, tag);
  endtask

  initial begin
    logic [W-1:0] m, p447, e448, sub_out;
    m = MODULUS;
    p447 = '0; p447[W-1] = 1'b1;
    e448 = '0; e448[224] = 1'b1; e448[0] = 1'b1;  // 2^448 = p + 2^224 + 1
    sub_out = m - W'(1);                          // 1 - 2 mod p from the subtractor
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;

    tick();
    tick();
    chk("reset result", bus.result, '0);
    chk("reset done", W'(bus.done), W'(0));
    chk("reset busy", W'(bus.busy), W'(0));

    // start on the first edge after reset release
    rst = 1'b0;
    run_op(W'(3), W'(5), W'(15), "3x5");
    tick(); tick(); tick();
    chk("done hold", W'(bus.done), W'(1));
    chk("result hold", bus.result, W'(15));

    run_op(m - W'(1), m - W'(1), W'(1), "(p-1)^2");
    run_op(m - W'(1), W'(2), m - W'(2), "(p-1)x2");
    run_op(W'(0), m - W'(1), W'(0), "0x(p-1)");
    run_op(W'(1), W'(16'h1234), W'(16'h1234), "1x1234");
    run_op(W'(7), sub_out, m - W'(7), "chain 7x(1-2)");
    run_op(p447, W'(2), e448, "2^447x2");

    // start with new operands mid-run is ignored; operand changes too
    issue(W'(3), W'(5), "ignore");
    repeat (99) tick();
    bus.a = W'(9);
    bus.b = W'(9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ignore busy", W'(bus.busy), W'(1));
    wait_done(LAT - 100, W'(15), "ignore");

    // reset aborts a run
    issue(W'(3), W'(5), "abort");
    repeat (199) tick();
    rst = 1'b1;
    tick();
    chk("abort result", bus.result, '0);
    chk("abort done", W'(bus.done), W'(0));
    chk("abort busy", W'(bus.busy), W'(0));
    rst = 1'b0;
    repeat (LAT + 5) tick();
    chk("abort no done", W'(bus.done), W'(0));
    run_op(W'(2), W'(2), W'(4), "2x2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
